// File: rtl/sequence_memory.sv
// Purpose: stores the memory-game sequence, plays it back with on/off timing and checks player entries.
// Latency: one APPEND cycle per round; match/error/round_done are registered, one cycle after input_valid.
// Backpressure: none; pulses outside their accepting state are dropped, and start aborts any activity.
module sequence_memory #(
   parameter int N          = 3,
   parameter int DEPTH      = 16,
   parameter int IDX_W      = 4,
   parameter int ON_CYCLES  = 25000000,
   parameter int OFF_CYCLES = 12500000,
   parameter int TIMER_W    = 26
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             next_round,
   input  logic [N-1:0]     rnd_address,
   output logic             rnd_enable,
   output logic             play_valid,
   output logic [N-1:0]     play_address,
   input  logic             input_valid,
   input  logic [N-1:0]     input_address,
   output logic             match,
   output logic             error,
   output logic             round_done,
   output logic             busy,
   output logic             seq_full,
   output logic [IDX_W:0]   length
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      APPEND   = 3'd1,
      SHOW_ON  = 3'd2,
      SHOW_OFF = 3'd3,
      WAIT_IN  = 3'd4
   } state_t;

   localparam logic [IDX_W:0]     LEN_ONE   = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W:0]     LEN_FULL  = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0]   IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [TIMER_W-1:0] TIMER_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};
   localparam logic [TIMER_W-1:0] ON_LAST   = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LAST  = TIMER_W'(OFF_CYCLES - 1);

   state_t             state;
   logic [N-1:0]       mem [DEPTH];
   logic [IDX_W-1:0]   idx;
   logic [TIMER_W-1:0] timer;

   logic [IDX_W:0]     last_pos;
   logic               idx_is_last;
   logic [N-1:0]       cur_entry;
   logic               write_entry;

   // Helper decodes: position of the final stored entry and the entry under idx.
   always_comb begin
      last_pos    = length - LEN_ONE;
      idx_is_last = ({1'b0, idx} == last_pos);
      cur_entry   = mem[idx];
      // The append write is suppressed whenever reset or start pre-empts APPEND.
      write_entry = reset && !start && (state == APPEND);
   end

   // Moore output decode straight from the state and registered counters.
   always_comb begin
      rnd_enable   = (state == APPEND);
      busy         = (state != IDLE);
      play_valid   = (state == SHOW_ON);
      play_address = (state == SHOW_ON) ? cur_entry : '0;
      seq_full     = (length == LEN_FULL);
   end

   // Sequence storage; never cleared, since only entries below length are ever read.
   always_ff @(posedge clock) begin
      if (write_entry) begin
         mem[length[IDX_W-1:0]] <= rnd_address;
      end
   end

   // Game FSM: append, timed playback, then entry checking with registered result pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         length     <= '0;
         idx        <= '0;
         timer      <= '0;
         match      <= 1'b0;
         error      <= 1'b0;
         round_done <= 1'b0;
      end else begin
         match      <= 1'b0;
         error      <= 1'b0;
         round_done <= 1'b0;
         if (start) begin
            // A new game discards the stored sequence; APPEND refills entry 0.
            length <= '0;
            idx    <= '0;
            timer  <= '0;
            state  <= APPEND;
         end else begin
            case (state)
               IDLE: begin
                  if (next_round) begin
                     if (length == LEN_FULL) begin
                        // Sequence is full: replay without growing it.
                        idx   <= '0;
                        timer <= '0;
                        state <= SHOW_ON;
                     end else if (length != '0) begin
                        state <= APPEND;
                     end
                  end
               end
               APPEND: begin
                  // The generator advances on this same edge, so the pre-advance value is stored.
                  length <= length + LEN_ONE;
                  idx    <= '0;
                  timer  <= '0;
                  state  <= SHOW_ON;
               end
               SHOW_ON: begin
                  if (timer == ON_LAST) begin
                     timer <= '0;
                     state <= SHOW_OFF;
                  end else begin
                     timer <= timer + TIMER_ONE;
                  end
               end
               SHOW_OFF: begin
                  if (timer == OFF_LAST) begin
                     timer <= '0;
                     if (idx_is_last) begin
                        idx   <= '0;
                        state <= WAIT_IN;
                     end else begin
                        idx   <= idx + IDX_ONE;
                        state <= SHOW_ON;
                     end
                  end else begin
                     timer <= timer + TIMER_ONE;
                  end
               end
               WAIT_IN: begin
                  // No timeout here: the controller leaves this state with start.
                  if (input_valid) begin
                     if (input_address == cur_entry) begin
                        match <= 1'b1;
                        if (idx_is_last) begin
                           round_done <= 1'b1;
                           idx        <= '0;
                           state      <= IDLE;
                        end else begin
                           idx <= idx + IDX_ONE;
                        end
                     end else begin
                        error <= 1'b1;
                        idx   <= '0;
                        state <= IDLE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sequence_memory.sv
// Purpose: self-checking bench for sequence_memory against a schedule-based behavioural model.
// Latency: model predicts outputs per cycle; compared on every falling edge.
// Backpressure: none; stimulus is directed scenarios followed by randomized traffic.
module tb_sequence_memory;

   localparam int N     = 3;
   localparam int DEPTH = 4;
   localparam int IDX_W = 2;
   localparam int ON    = 4;
   localparam int OFF   = 2;
   localparam int TW    = 4;
   localparam int P     = ON + OFF;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic           next_round = 1'b0;
   logic [N-1:0]   rnd_address = '0;
   logic           input_valid = 1'b0;
   logic [N-1:0]   input_address = '0;
   logic           rnd_enable, play_valid, match, error, round_done, busy, seq_full;
   logic [N-1:0]   play_address;
   logic [IDX_W:0] length;

   sequence_memory #(
      .N(N), .DEPTH(DEPTH), .IDX_W(IDX_W),
      .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMER_W(TW)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .next_round(next_round),
      .rnd_address(rnd_address), .rnd_enable(rnd_enable),
      .play_valid(play_valid), .play_address(play_address),
      .input_valid(input_valid), .input_address(input_address),
      .match(match), .error(error), .round_done(round_done),
      .busy(busy), .seq_full(seq_full), .length(length)
   );

   int total = 0;
   int passed = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: a round is a schedule of len entries, each P cycles long,
   // entry k shown during the first ON cycles of slot k.
   typedef enum {M_IDLE, M_APPEND, M_PLAY, M_WAIT} mphase_t;
   mphase_t mph = M_IDLE;
   int  mseq [DEPTH];
   int  mlen = 0;
   int  mt = 0;
   int  mpos = 0;
   bit  e_match = 0, e_error = 0, e_done = 0;

   task automatic model_step();
      e_match = 0; e_error = 0; e_done = 0;
      if (!reset) begin
         mph = M_IDLE; mlen = 0; mpos = 0; mt = 0;
      end else if (start) begin
         mlen = 0; mph = M_APPEND;
      end else begin
         case (mph)
            M_IDLE: if (next_round) begin
               if (mlen == DEPTH) begin mph = M_PLAY; mt = 0; end
               else if (mlen > 0) mph = M_APPEND;
            end
            M_APPEND: begin
               mseq[mlen] = int'(rnd_address);
               mlen++;
               mph = M_PLAY; mt = 0;
            end
            M_PLAY: begin
               mt++;
               if (mt == mlen * P) begin mph = M_WAIT; mpos = 0; end
            end
            M_WAIT: if (input_valid) begin
               if (int'(input_address) == mseq[mpos]) begin
                  e_match = 1;
                  if (mpos == mlen - 1) begin e_done = 1; mph = M_IDLE; end
                  else mpos++;
               end else begin
                  e_error = 1; mph = M_IDLE;
               end
            end
            default: mph = M_IDLE;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   // Per-cycle compare of every DUT output against the model.
   initial forever begin
      int epv, epa;
      @(negedge clock);
      epv = (mph == M_PLAY && (mt % P) < ON) ? 1 : 0;
      epa = epv ? mseq[mt / P] : 0;
      check("rnd_enable",   int'(rnd_enable),   (mph == M_APPEND) ? 1 : 0);
      check("busy",         int'(busy),         (mph != M_IDLE) ? 1 : 0);
      check("play_valid",   int'(play_valid),   epv);
      check("play_address", int'(play_address), epa);
      check("match",        int'(match),        int'(e_match));
      check("error",        int'(error),        int'(e_error));
      check("round_done",   int'(round_done),   int'(e_done));
      check("length",       int'(length),       mlen);
      check("seq_full",     int'(seq_full),     (mlen == DEPTH) ? 1 : 0);
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic enter(input int a);
      input_valid = 1'b1;
      input_address = N'(a);
      tick();
      input_valid = 1'b0;
   endtask

   int played [$];

   // Drives one round from its first cycle until the model reaches WAIT, recording observations.
   task automatic run_round(input bit st, input bit nr, input int a, input bit noise,
                            output int en_cnt, output int pv_cnt);
      bit prev_pv = 0;
      bit done = 0;
      en_cnt = 0; pv_cnt = 0;
      played.delete();
      start = st; next_round = nr; rnd_address = N'(a);
      for (int c = 0; c < 200 && !done; c++) begin
         if (noise && c > 0) begin
            input_valid = 1'($urandom_range(0, 1));
            input_address = N'($urandom);
         end
         tick();
         start = 1'b0; next_round = 1'b0; input_valid = 1'b0;
         en_cnt += int'(rnd_enable);
         pv_cnt += int'(play_valid);
         if (play_valid && !prev_pv) played.push_back(int'(play_address));
         prev_pv = play_valid;
         if (mph == M_WAIT) done = 1;
      end
      if (!done) check("wait_in_timeout", 0, 1);
   endtask

   initial begin
      int en, pv;
      bit found;
      // Reset held low for two edges.
      tick(); tick();
      check("reset_length", int'(length), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_play_valid", int'(play_valid), 0);
      reset = 1'b1;

      // First game: start with 5.
      run_round(1, 0, 5, 0, en, pv);
      check("first_rnd_enable_cycles", en, 1);
      check("first_play_cycles", pv, 4);
      check("first_played_count", played.size(), 1);
      if (played.size() > 0) check("first_played_addr", played[0], 5);
      check("first_length", int'(length), 1);
      check("first_wait_busy", int'(busy), 1);
      enter(5);
      check("first_match", int'(match), 1);
      check("first_round_done", int'(round_done), 1);
      check("first_idle_busy", int'(busy), 0);

      // Second round: append 2, then 5 correct and 3 wrong.
      run_round(0, 1, 2, 0, en, pv);
      check("r2_rnd_enable_cycles", en, 1);
      check("r2_play_cycles", pv, 8);
      if (played.size() == 2) begin
         check("r2_played0", played[0], 5);
         check("r2_played1", played[1], 2);
      end else check("r2_played_count", played.size(), 2);
      enter(5);
      check("r2_match", int'(match), 1);
      check("r2_no_error", int'(error), 0);
      enter(3);
      check("r2_error", int'(error), 1);
      check("r2_no_match", int'(match), 0);
      check("r2_idle", int'(busy), 0);
      check("r2_length", int'(length), 2);

      // Grow to full.
      run_round(0, 1, 7, 0, en, pv);
      enter(5); enter(2); enter(7);
      check("r3_round_done", int'(round_done), 1);
      run_round(0, 1, 1, 0, en, pv);
      enter(5); enter(2); enter(7); enter(1);
      check("r4_round_done", int'(round_done), 1);
      check("full_length", int'(length), 4);
      check("full_seq_full", int'(seq_full), 1);

      // Full replay, with ignored input pulses during playback.
      run_round(0, 1, 6, 1, en, pv);
      check("full_no_append", en, 0);
      check("full_play_cycles", pv, 16);
      if (played.size() == 4) begin
         check("full_played0", played[0], 5);
         check("full_played1", played[1], 2);
         check("full_played2", played[2], 7);
         check("full_played3", played[3], 1);
      end else check("full_played_count", played.size(), 4);
      enter(5); enter(2); enter(7); enter(1);
      check("full_round_done", int'(round_done), 1);

      // Abort with start during entry 2's show phase.
      run_round(1, 0, 3, 0, en, pv);
      enter(3);
      next_round = 1'b1; rnd_address = 3'd6;
      tick();
      next_round = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (mph == M_PLAY && mt == P + 1) found = 1;
         else tick();
      end
      if (!found) check("abort_reach_timeout", 0, 1);
      check("abort_showing_entry2", int'(play_address), 6);
      start = 1'b1; rnd_address = 3'd4;
      tick();
      start = 1'b0;
      check("abort_append", int'(rnd_enable), 1);
      tick();
      check("abort_length", int'(length), 1);
      check("abort_new_play", int'(play_valid), 1);
      check("abort_new_addr", int'(play_address), 4);
      run_round(0, 0, 4, 0, en, pv);

      // Reset during WAIT_IN.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("wait_reset_busy", int'(busy), 0);
      check("wait_reset_length", int'(length), 0);
      check("wait_reset_play_valid", int'(play_valid), 0);
      check("wait_reset_rnd_enable", int'(rnd_enable), 0);

      // start and next_round together: start wins.
      run_round(1, 1, 6, 0, en, pv);
      check("both_length", int'(length), 1);
      check("both_rnd_enable_cycles", en, 1);
      enter(6);
      check("both_round_done", int'(round_done), 1);

      // Randomized traffic checked by the model every cycle.
      for (int c = 0; c < 2000; c++) begin
         reset = ($urandom_range(0, 299) != 0);
         start = ($urandom_range(0, 59) == 0);
         next_round = ($urandom_range(0, 7) == 0);
         rnd_address = N'($urandom);
         input_valid = ($urandom_range(0, 3) == 0);
         if (mph == M_WAIT && $urandom_range(0, 9) < 8) input_address = N'(mseq[mpos]);
         else input_address = N'($urandom);
         tick();
      end
      start = 1'b0; next_round = 1'b0; input_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sequence_memory.md
Name: sequence_memory

Overview:
- Downstream consumer of the random address generator in the memory-game datapath.
- Grows a stored sequence one random address per round and plays it back with on/off timing for the LED/display stage.
- Checks the player's button entries against the stored sequence and reports match, mismatch or round completion to the game controller.

Parameters:
- N, 3, address width; must equal the random generator's N.
- DEPTH, 16, maximum sequence length in entries.
- IDX_W, 4, index width; clog2(DEPTH).
- ON_CYCLES, 25000000, cycles each played entry is shown (play_valid high); must be ≥1.
- OFF_CYCLES, 12500000, blank cycles after each shown entry; must be ≥1.
- TIMER_W, 26, phase timer width; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- clock, input, 1, system clock; all logic on posedge.
- reset, input, 1, synchronous, active-low; asserted when 0.
- start, input, 1, pulse: discard the sequence, begin a new game.
- next_round, input, 1, pulse: append one entry and replay (IDLE only).
- rnd_address, input, N, current random generator output.
- rnd_enable, output, 1, drives the generator's write_enable; advances the LFSR.
- play_valid, output, 1, high while an entry is shown.
- play_address, output, N, entry being shown; 0 when play_valid=0.
- input_valid, input, 1, one-cycle pulse per player entry.
- input_address, input, N, player entry.
- match, output, 1, one-cycle pulse: entry correct.
- error, output, 1, one-cycle pulse: entry wrong.
- round_done, output, 1, one-cycle pulse: whole sequence entered correctly.
- busy, output, 1, state != IDLE.
- seq_full, output, 1, length == DEPTH.
- length, output, IDX_W+1, number of stored entries.

Behaviour:
- Reset (reset=0 at posedge):
  - State IDLE; length=0, idx=0, timer=0.
  - All outputs 0.
  - Memory contents not cleared; entries at or beyond length are never read.
- Priority: reset > start > next_round > input_valid.
- start is accepted in any state, aborting playback or entry: length←0, go APPEND.
- IDLE:
  - next_round with 0 < length < DEPTH: go APPEND.
  - next_round with length == DEPTH: go SHOW_ON, no append, idx=0.
  - next_round with length == 0: ignored.
- APPEND (exactly 1 cycle):
  - rnd_enable=1 (Moore decode of state).
  - mem[length]←rnd_address; length←length+1; idx←0; timer←0.
  - Next state SHOW_ON.
  - The generator advances on the same edge, so the captured value is the pre-advance address.
- SHOW_ON: play_valid=1, play_address=mem[idx] for exactly ON_CYCLES cycles, then SHOW_OFF with timer←0.
- SHOW_OFF: play_valid=0 for exactly OFF_CYCLES cycles.
  - If idx == length-1: go WAIT_IN, idx←0.
  - Otherwise: idx←idx+1, go SHOW_ON.
- WAIT_IN, on input_valid, compare input_address with mem[idx]:
  - Equal and idx < length-1: match pulse next cycle; idx←idx+1.
  - Equal and idx == length-1: match and round_done pulse together next cycle; go IDLE.
  - Unequal: error pulse next cycle; go IDLE; length unchanged.
- input_valid outside WAIT_IN is ignored; no pulses are generated.
- match, error and round_done are registered; they fire 1 cycle after the input_valid sample and never overlap with error.
- next_round outside IDLE is ignored.
- No timeout in WAIT_IN; the controller aborts via start.
- length saturates at DEPTH; no wrap-around.

Test Plan:
Bench config: N=3, DEPTH=4, ON_CYCLES=4, OFF_CYCLES=2.
- Reset low 2 cycles, then release: all outputs 0, length=0, busy=0. Then start with rnd_address=5:
  - rnd_enable high exactly 1 cycle; length=1.
  - play_valid high 4 cycles with play_address=5, then low 2 cycles.
  - WAIT_IN reached with busy=1.
- In WAIT_IN after the first scenario, input 5: match=1 and round_done=1 on the following cycle, then IDLE with busy=0.
- next_round with rnd_address=2: plays 5 then 2, timed 4/2/4/2. Inputs 5 then 3:
  - match pulse after the first input.
  - error pulse after the second input, then IDLE.
  - length stays 2.
- Rounds until length=4, then next_round: no rnd_enable pulse; seq_full=1; all 4 stored entries replayed in order.
- Abort and reset mid-operation:
  - start asserted during SHOW_ON of entry 2: APPEND next cycle, length=1, new sequence plays.
  - reset=0 during WAIT_IN: IDLE with all outputs 0 after that edge.
- Simultaneous and ignored inputs:
  - start and next_round in the same cycle: start wins, length=1.
  - input_valid pulses during SHOW_ON/SHOW_OFF: no match/error pulses and idx unchanged.
